// File: rtl/req_order_queue_pkg.sv
// ---------------------------------------------------------------------------
// req_queue_pkg
// Shared helpers for the arrival-order request queue.
//   clog2_min1 : ceil(log2(value)) but never less than 1, so that a one-entry
//                or two-requester configuration still gets a real bit.
//   onehot_of  : one-hot vector (MAX_N wide) with bit idx set; callers cast
//                the result down to their own requester count.
// ---------------------------------------------------------------------------
package req_queue_pkg;

    localparam int unsigned MAX_N = 64;

    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    function automatic logic [MAX_N-1:0] onehot_of(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] oh;
        if (idx < n) begin
            oh = MAX_N'(1'b1) << idx;
        end else begin
            oh = '0;
        end
        return oh;
    endfunction

endpackage

// File: rtl/req_order_queue_checker.sv
// ---------------------------------------------------------------------------
// req_order_queue_checker
// Structural invariants of req_order_queue, observed at its ports.
// Ports:
//   clk, rst_n  clock / async active-low reset of the observed queue
//   pending     pending vector of the queue
//   count       occupancy of the queue
// ---------------------------------------------------------------------------
module req_order_queue_checker #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    input logic [N-1:0]     pending,
    input logic [CNT_W-1:0] count
);

    // Each requester owns at most one entry, so pending bits equal occupancy.
    a_pending_matches_count : assert property (
        @(posedge clk) disable iff (!rst_n) ($countones(pending) == int'(count)));

    a_count_bounded : assert property (
        @(posedge clk) disable iff (!rst_n) (int'(count) <= DEPTH));

endmodule

// File: rtl/req_order_queue_lsb_first_encoder.sv
// ---------------------------------------------------------------------------
// lsb_first_encoder
// Picks the lowest-numbered set bit of a request vector.
// Ports:
//   in_i  [N]     candidate vector
//   any_o         at least one bit of in_i is set
//   idx_o [IDX_W] index of the lowest set bit (0 when any_o=0)
// ---------------------------------------------------------------------------
module lsb_first_encoder
    import req_queue_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     in_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the last hit (the lowest index) wins.
    always_comb begin
        any_o = |in_i;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o = IDX_W'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/req_order_queue.sv
// ---------------------------------------------------------------------------
// req_order_queue
// Arrival-order queue of requester indices. Each requester holds at most one
// entry; the oldest live entry is presented to a downstream grant stage.
// A requester re-asserting after being served lands at the tail, giving
// round-robin fairness. With DROP_STALE=1 a head entry whose request has
// gone away is discarded automatically (one per cycle).
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req   [N]    level request per requester
//   pop          consume head entry (ignored when head_valid=0)
//   head_valid   head entry present and live
//   head_idx     head requester index, 0 when not valid
//   head_onehot  one-hot of head_idx, 0 when not valid
//   pending [N]  registered: requester holds an entry
//   count        occupied entries including stale ones
//   is_full      count == DEPTH
//   is_empty     count == 0
// ---------------------------------------------------------------------------
module req_order_queue
    import req_queue_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEPTH      = 4,
    parameter bit DROP_STALE = 1'b1,
    localparam int IDX_W     = clog2_min1(N),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             pop,
    output logic             head_valid,
    output logic [IDX_W-1:0] head_idx,
    output logic [N-1:0]     head_onehot,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] count,
    output logic             is_full,
    output logic             is_empty
);

    localparam int PTR_W = clog2_min1(DEPTH);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     pending_q, pending_d;

    logic [N-1:0]     new_req_s;
    logic             any_new_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] head_entry_s;
    logic             head_req_s;
    logic             is_full_s;
    logic             is_empty_s;
    logic             live_s;
    logic             drop_s;
    logic             remove_s;
    logic             enq_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Only requesters without an entry may compete for the single enqueue slot.
    assign new_req_s = req & ~pending_q;

    lsb_first_encoder #(.N(N), .IDX_W(IDX_W)) u_enc (
        .in_i  (new_req_s),
        .any_o (any_new_s),
        .idx_o (winner_s)
    );

    // Head decode plus enqueue/removal decisions for this cycle.
    always_comb begin
        head_entry_s = mem_q[rd_ptr_q];
        head_req_s   = req[head_entry_s];
        is_empty_s   = (count_q == '0);
        is_full_s    = (count_q == CNT_W'(DEPTH));
        live_s       = ~is_empty_s & (~DROP_STALE | head_req_s);
        drop_s       = DROP_STALE & ~is_empty_s & ~head_req_s;
        // A removal frees a slot, so a full queue can still accept this cycle.
        remove_s     = (pop & live_s) | drop_s;
        enq_s        = any_new_s & (~is_full_s | remove_s);
    end

    // Next-state pointers, occupancy and pending vector.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pending_d = pending_q;
        if (remove_s) begin
            rd_ptr_d                = ptr_inc(rd_ptr_q);
            pending_d[head_entry_s] = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // The winner is never the removed head: the head is still pending.
        if (enq_s) begin
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            pending_d[winner_s] = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({enq_s, remove_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_q[wr_ptr_q] <= winner_s;
        end
    end

    assign head_valid  = live_s;
    assign head_idx    = live_s ? head_entry_s : '0;
    assign head_onehot = live_s ? N'(onehot_of(32'(head_entry_s), N)) : '0;
    assign pending     = pending_q;
    assign count       = count_q;
    assign is_full     = is_full_s;
    assign is_empty    = is_empty_s;

endmodule

// File: tb/tb_req_order_queue.sv
// ---------------------------------------------------------------------------
// tb_req_order_queue
// Three queue instances share req/pop: A (DEPTH=4, drop), B (DEPTH=2, drop),
// C (DEPTH=4, no drop). A queue-level model tracks all three every cycle;
// directed tables and sequences pin the documented corner cases.
// ---------------------------------------------------------------------------
module tb_req_order_queue;

    localparam int ND = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_s = 4'b0000;
    logic       pop_s = 1'b0;

    logic       a_hv, b_hv, c_hv;
    logic [1:0] a_idx, b_idx, c_idx;
    logic [3:0] a_oh, b_oh, c_oh;
    logic [3:0] a_pend, b_pend, c_pend;
    logic [2:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;
    logic       a_full, b_full, c_full;
    logic       a_empty, b_empty, c_empty;

    logic       o_hv    [ND];
    logic [1:0] o_idx   [ND];
    logic [3:0] o_oh    [ND];
    logic [3:0] o_pend  [ND];
    logic [2:0] o_cnt   [ND];
    logic       o_full  [ND];
    logic       o_empty [ND];

    int mq [ND][4];
    int mn [ND];
    bit armed = 1'b0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    req_order_queue #(.N(4), .DEPTH(4), .DROP_STALE(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_s), .pop(pop_s),
        .head_valid(a_hv), .head_idx(a_idx), .head_onehot(a_oh), .pending(a_pend),
        .count(a_cnt), .is_full(a_full), .is_empty(a_empty));

    req_order_queue #(.N(4), .DEPTH(2), .DROP_STALE(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_s), .pop(pop_s),
        .head_valid(b_hv), .head_idx(b_idx), .head_onehot(b_oh), .pending(b_pend),
        .count(b_cnt), .is_full(b_full), .is_empty(b_empty));

    req_order_queue #(.N(4), .DEPTH(4), .DROP_STALE(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_s), .pop(pop_s),
        .head_valid(c_hv), .head_idx(c_idx), .head_onehot(c_oh), .pending(c_pend),
        .count(c_cnt), .is_full(c_full), .is_empty(c_empty));

    req_order_queue_checker #(.N(4), .DEPTH(4), .CNT_W(3)) u_chk_a (
        .clk(clk), .rst_n(rst_n), .pending(a_pend), .count(a_cnt));

    req_order_queue_checker #(.N(4), .DEPTH(2), .CNT_W(2)) u_chk_b (
        .clk(clk), .rst_n(rst_n), .pending(b_pend), .count(b_cnt));

    always_comb begin
        o_hv[0] = a_hv;   o_idx[0] = a_idx;  o_oh[0] = a_oh;  o_pend[0] = a_pend;
        o_cnt[0] = a_cnt; o_full[0] = a_full; o_empty[0] = a_empty;
        o_hv[1] = b_hv;   o_idx[1] = b_idx;  o_oh[1] = b_oh;  o_pend[1] = b_pend;
        o_cnt[1] = {1'b0, b_cnt}; o_full[1] = b_full; o_empty[1] = b_empty;
        o_hv[2] = c_hv;   o_idx[2] = c_idx;  o_oh[2] = c_oh;  o_pend[2] = c_pend;
        o_cnt[2] = c_cnt; o_full[2] = c_full; o_empty[2] = c_empty;
    end

    function automatic int dep_of(input int k);
        return (k == 1) ? 2 : 4;
    endfunction

    function automatic bit drop_of(input int k);
        return (k != 2);
    endfunction

    function automatic bit bit_of(input logic [3:0] v, input int i);
        logic [1:0] sel;
        sel = i[1:0];
        return v[sel];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_pend(input int k);
        logic [3:0] p;
        p = 4'b0000;
        for (int i = 0; i < mn[k]; i++) p = p | (4'b0001 << mq[k][i]);
        return p;
    endfunction

    task automatic model_check(input int k);
        int head;
        bit live;
        head = (mn[k] > 0) ? mq[k][0] : 0;
        live = (mn[k] > 0) && (!drop_of(k) || bit_of(req_s, head));
        chk($sformatf("dut%0d head_valid", k), 32'(o_hv[k]), 32'(live));
        chk($sformatf("dut%0d head_idx", k), 32'(o_idx[k]), live ? head : 0);
        chk($sformatf("dut%0d head_onehot", k), 32'(o_oh[k]), live ? (32'd1 << head) : 32'd0);
        chk($sformatf("dut%0d pending", k), 32'(o_pend[k]), 32'(model_pend(k)));
        chk($sformatf("dut%0d count", k), 32'(o_cnt[k]), mn[k]);
        chk($sformatf("dut%0d is_full", k), 32'(o_full[k]), 32'(mn[k] == dep_of(k)));
        chk($sformatf("dut%0d is_empty", k), 32'(o_empty[k]), 32'(mn[k] == 0));
    endtask

    // Apply one clock edge's worth of queue rules using the inputs held at that edge.
    task automatic model_step(input int k);
        int head, win;
        bit live, remove, enq;
        logic [3:0] newv;
        head   = (mn[k] > 0) ? mq[k][0] : 0;
        live   = (mn[k] > 0) && (!drop_of(k) || bit_of(req_s, head));
        remove = (pop_s && live) || (drop_of(k) && mn[k] > 0 && !bit_of(req_s, head));
        newv   = req_s & ~model_pend(k);
        win    = -1;
        for (int i = 3; i >= 0; i--) if (bit_of(newv, i)) win = i;
        enq    = (win >= 0) && (mn[k] < dep_of(k) || remove);
        if (remove) begin
            for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
            mn[k]--;
        end
        if (enq) begin
            mq[k][mn[k]] = win;
            mn[k]++;
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic p);
        @(negedge clk);
        if (armed) for (int k = 0; k < ND; k++) model_step(k);
        req_s = r;
        pop_s = p;
        #1;
        for (int k = 0; k < ND; k++) model_check(k);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        armed = 1'b0;
        req_s = 4'b0000;
        pop_s = 1'b0;
        for (int k = 0; k < ND; k++) mn[k] = 0;
        #1;
        for (int k = 0; k < ND; k++) model_check(k);
        @(negedge clk);
        rst_n = 1'b1;
        armed = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       pop;
        logic       hv;
        logic [1:0] idx;
        logic [2:0] cnt;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [3:0] r;
        logic [3:0] exp_oh;

        // Single request, then a burst 1011 served in index order, then stale drain.
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 3'd0, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 3'd1, 4'b0100};
        tbl[2]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 3'd1, 4'b0100};
        tbl[3]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 4'b0000};
        tbl[4]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 3'd0, 4'b0000};
        tbl[5]  = '{4'b1011, 1'b0, 1'b1, 2'd0, 3'd1, 4'b0001};
        tbl[6]  = '{4'b1011, 1'b0, 1'b1, 2'd0, 3'd2, 4'b0011};
        tbl[7]  = '{4'b1011, 1'b0, 1'b1, 2'd0, 3'd3, 4'b1011};
        tbl[8]  = '{4'b1011, 1'b1, 1'b1, 2'd0, 3'd3, 4'b1011};
        tbl[9]  = '{4'b1011, 1'b1, 1'b1, 2'd1, 3'd2, 4'b1010};
        tbl[10] = '{4'b1011, 1'b1, 1'b1, 2'd3, 3'd2, 4'b1001};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 2'd0, 3'd2, 4'b0011};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 2'd0, 3'd1, 4'b0010};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 4'b0000};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].req, tbl[i].pop);
            exp_oh = tbl[i].hv ? (4'b0001 << tbl[i].idx) : 4'b0000;
            chk($sformatf("tbl%0d head_valid", i), 32'(a_hv), 32'(tbl[i].hv));
            chk($sformatf("tbl%0d head_idx", i), 32'(a_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d head_onehot", i), 32'(a_oh), 32'(exp_oh));
            chk($sformatf("tbl%0d count", i), 32'(a_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d pending", i), 32'(a_pend), 32'(tbl[i].pend));
        end

        // Fairness: 0011 held with pop every cycle alternates grants 0,1,0,1.
        do_reset();
        drive(4'b0011, 1'b1);
        chk("fair first head_valid", 32'(a_hv), 32'd0);
        for (int i = 0; i < 6; i++) begin
            drive(4'b0011, 1'b1);
            chk($sformatf("fair%0d head_idx", i), 32'(a_idx), 32'(i % 2));
            chk($sformatf("fair%0d head_valid", i), 32'(a_hv), 32'd1);
            chk($sformatf("fair%0d count", i), 32'(a_cnt), 32'd1);
        end

        // Full at DEPTH=2: pop and enqueue in one cycle keep count at 2.
        do_reset();
        drive(4'b1111, 1'b0);
        drive(4'b1111, 1'b0);
        drive(4'b1111, 1'b0);
        chk("full is_full", 32'(b_full), 32'd1);
        chk("full count", 32'(b_cnt), 32'd2);
        chk("full pending", 32'(b_pend), 32'd3);
        drive(4'b1111, 1'b1);
        chk("full pop head_idx", 32'(b_idx), 32'd0);
        drive(4'b1111, 1'b0);
        chk("full after head_idx", 32'(b_idx), 32'd1);
        chk("full after count", 32'(b_cnt), 32'd2);
        chk("full after pending", 32'(b_pend), 32'b0110);

        // Stale drop: {1,2,3} then only requester 3 stays asserted.
        do_reset();
        for (int i = 0; i < 4; i++) drive(4'b1110, 1'b0);
        chk("stale setup count", 32'(a_cnt), 32'd3);
        chk("stale setup head_idx", 32'(a_idx), 32'd1);
        drive(4'b1000, 1'b0);
        chk("stale d1 head_valid", 32'(a_hv), 32'd0);
        chk("stale d1 count", 32'(a_cnt), 32'd3);
        chk("stale nodrop d1 head_idx", 32'(c_idx), 32'd1);
        drive(4'b1000, 1'b0);
        chk("stale d2 head_valid", 32'(a_hv), 32'd0);
        chk("stale d2 count", 32'(a_cnt), 32'd2);
        drive(4'b1000, 1'b0);
        chk("stale d3 head_valid", 32'(a_hv), 32'd1);
        chk("stale d3 head_idx", 32'(a_idx), 32'd3);
        chk("stale nodrop d3 head_idx", 32'(c_idx), 32'd1);
        chk("stale nodrop d3 count", 32'(c_cnt), 32'd3);

        // Async reset mid-stream with C holding three entries.
        drive(4'b1110, 1'b0);
        chk("areset pre count", 32'(c_cnt), 32'd3);
        #1;
        rst_n = 1'b0;
        armed = 1'b0;
        for (int k = 0; k < ND; k++) mn[k] = 0;
        #1;
        chk("areset head_valid", 32'(c_hv), 32'd0);
        chk("areset pending", 32'(c_pend), 32'd0);
        chk("areset count", 32'(c_cnt), 32'd0);
        chk("areset is_empty", 32'(c_empty), 32'd1);
        for (int k = 0; k < ND; k++) model_check(k);
        @(negedge clk);
        rst_n = 1'b1;
        armed = 1'b1;
        drive(4'b1110, 1'b0);
        chk("areset restart head_idx", 32'(c_idx), 32'd1);
        chk("areset restart head_valid", 32'(c_hv), 32'd1);
        chk("areset restart count", 32'(c_cnt), 32'd1);

        // Random traffic against the model.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            drive(r, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
